// File: rtl/cv_sched_pkg.sv
// Shared types and constants for the CV frame scheduler.
// Optional slewing of applied CV words is enabled with the CV_SLEW_EN macro.
package cv_sched_pkg;

    localparam int NUM_CV    = 7;
    localparam int CV_WIDTH  = 16;
    localparam int WD_WIDTH  = 22;
    localparam int IDX_WIDTH = 3;

    localparam logic [CV_WIDTH-1:0] SLEW_STEP = 16'd512;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CAPTURE = 3'd1,
        ST_PENDING = 3'd2,
        ST_APPLY   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    typedef logic [CV_WIDTH-1:0] cv_word_t;

endpackage

// File: rtl/cv_slew_step.sv
// One-channel rate limiter: moves current toward target by at most step.
// Works in 17 bits so the result never wraps past 0 or full scale.
module cv_slew_step
    import cv_sched_pkg::*;
(
    input  logic [CV_WIDTH-1:0] target_i,
    input  logic [CV_WIDTH-1:0] current_i,
    input  logic [CV_WIDTH-1:0] step_i,
    output logic [CV_WIDTH-1:0] next_o
);

    logic [CV_WIDTH:0] diff_s;

    // Compare the distance to the target against the allowed step
    always_comb begin
        if (target_i >= current_i) begin
            diff_s = {1'b0, target_i} - {1'b0, current_i};
            if (diff_s <= {1'b0, step_i}) begin
                next_o = target_i;
            end else begin
                next_o = current_i + step_i;
            end
        end else begin
            diff_s = {1'b0, current_i} - {1'b0, target_i};
            if (diff_s <= {1'b0, step_i}) begin
                next_o = target_i;
            end else begin
                next_o = current_i - step_i;
            end
        end
    end

endmodule

// File: rtl/cv_frame_scheduler.sv
// Captures CV frames from the SPI receiver and applies them on sample boundaries.
// CV_SLEW_EN: rate-limit each applied word and re-apply on idle ticks until settled.
module cv_frame_scheduler
    import cv_sched_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2400000
) (
    input  logic                         i_Clock,
    input  logic                         i_Reset,
    input  logic [NUM_CV*CV_WIDTH-1:0]   i_Frame_Data,
    input  logic                         i_Frame_Received,
    input  logic                         i_Sample_Tick,
    output logic [NUM_CV*CV_WIDTH-1:0]   o_CV,
    output logic                         o_CV_Valid,
    output logic                         o_Link_OK,
    output logic [7:0]                   o_Frame_Count
);

    localparam logic [WD_WIDTH-1:0]  WD_MAX   = WD_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_WIDTH-1:0] IDX_LAST = IDX_WIDTH'(NUM_CV - 1);

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 prev_q;
    logic                 frame_edge_s;
    state_e               state_q;
    logic [IDX_WIDTH-1:0] idx_q;
    cv_word_t             shadow_q [NUM_CV];
    cv_word_t             cv_q     [NUM_CV];
    logic                 pending_q;
    logic                 edge_pend_q;
    logic                 full_pass_q;
    logic                 unsettled_q;
    logic                 valid_q;
    logic                 link_q;
    logic [7:0]           count_q;
    logic [WD_WIDTH-1:0]  wd_q;
    logic [WD_WIDTH-1:0]  wd_d;
    cv_word_t             step_s;
    cv_word_t             next_word_s;
    logic                 diff_any_s;

    assign frame_edge_s = sync2_q & ~prev_q;

`ifdef CV_SLEW_EN
    assign step_s = SLEW_STEP;

    // Any channel still short of its shadow target after a pass
    always_comb begin
        diff_any_s = 1'b0;
        for (int k = 0; k < NUM_CV; k++) begin
            diff_any_s = diff_any_s | (cv_q[k] != shadow_q[k]);
        end
    end
`else
    // A full-scale step makes the limiter a direct copy of the target
    assign step_s     = {CV_WIDTH{1'b1}};
    assign diff_any_s = 1'b0;
`endif

    cv_slew_step u_slew (
        .target_i  (shadow_q[idx_q]),
        .current_i (cv_q[idx_q]),
        .step_i    (step_s),
        .next_o    (next_word_s)
    );

    // Saturating watchdog increment
    always_comb begin
        if (wd_q == WD_MAX) begin
            wd_d = wd_q;
        end else begin
            wd_d = wd_q + 22'd1;
        end
    end

    // Synchroniser, watchdog and sequencing FSM with registered outputs
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            state_q     <= ST_IDLE;
            idx_q       <= 3'd0;
            pending_q   <= 1'b0;
            edge_pend_q <= 1'b0;
            full_pass_q <= 1'b0;
            unsettled_q <= 1'b0;
            valid_q     <= 1'b0;
            link_q      <= 1'b0;
            count_q     <= 8'd0;
            wd_q        <= 22'd0;
            for (int k = 0; k < NUM_CV; k++) begin
                shadow_q[k] <= 16'd0;
                cv_q[k]     <= 16'd0;
            end
        end else begin
            sync1_q <= i_Frame_Received;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            wd_q    <= wd_d;
            valid_q <= 1'b0;
            if (wd_q == WD_MAX) begin
                link_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (frame_edge_s) begin
                        state_q <= ST_CAPTURE;
                    end else if (i_Sample_Tick && unsettled_q) begin
                        state_q     <= ST_APPLY;
                        idx_q       <= 3'd0;
                        full_pass_q <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    // Flag already dropped means the receiver started overwriting the frame
                    if (sync2_q) begin
                        for (int k = 0; k < NUM_CV; k++) begin
                            shadow_q[k] <= i_Frame_Data[k*CV_WIDTH +: CV_WIDTH];
                        end
                        wd_q      <= 22'd0;
                        link_q    <= 1'b1;
                        pending_q <= 1'b1;
                        state_q   <= ST_PENDING;
                    end else begin
                        state_q <= pending_q ? ST_PENDING : ST_IDLE;
                    end
                end
                ST_PENDING: begin
                    if (i_Sample_Tick) begin
                        state_q     <= ST_APPLY;
                        idx_q       <= 3'd0;
                        full_pass_q <= 1'b1;
                        pending_q   <= 1'b0;
                        if (frame_edge_s) begin
                            edge_pend_q <= 1'b1;
                        end
                    end else if (frame_edge_s) begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_APPLY: begin
                    cv_q[idx_q] <= next_word_s;
                    if (frame_edge_s) begin
                        edge_pend_q <= 1'b1;
                    end
                    if (idx_q == IDX_LAST) begin
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + 3'd1;
                    end
                end
                ST_DONE: begin
                    valid_q     <= 1'b1;
                    unsettled_q <= diff_any_s;
                    if (full_pass_q) begin
                        count_q <= count_q + 8'd1;
                    end
                    if (edge_pend_q || frame_edge_s) begin
                        edge_pend_q <= 1'b0;
                        state_q     <= ST_CAPTURE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Repack the applied bank onto the output bus
    always_comb begin
        o_CV = '0;
        for (int k = 0; k < NUM_CV; k++) begin
            o_CV[k*CV_WIDTH +: CV_WIDTH] = cv_q[k];
        end
    end

    assign o_CV_Valid    = valid_q;
    assign o_Link_OK     = link_q;
    assign o_Frame_Count = count_q;

endmodule

// File: tb/tb_cv_frame_scheduler.sv
// Directed bench for cv_frame_scheduler; watchdog shortened to 64 cycles.
module tb_cv_frame_scheduler;

    localparam int TB_TIMEOUT = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic [111:0] data;
    logic         flag;
    logic         tick;
    logic [111:0] cv;
    logic         cv_valid;
    logic         link_ok;
    logic [7:0]   fcount;

    int checks = 0;
    int errors = 0;

    cv_frame_scheduler #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .i_Clock          (clk),
        .i_Reset          (rst),
        .i_Frame_Data     (data),
        .i_Frame_Received (flag),
        .i_Sample_Tick    (tick),
        .o_CV             (cv),
        .o_CV_Valid       (cv_valid),
        .o_Link_OK        (link_ok),
        .o_Frame_Count    (fcount)
    );

    always #5 clk = ~clk;

    function automatic logic [111:0] seq_frame(input logic [15:0] base, input logic [15:0] stride);
        logic [111:0] f;
        for (int k = 0; k < 7; k++) f[k*16 +: 16] = base + stride * 16'(k);
        return f;
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; flag = 1'b0; tick = 1'b0; data = '0;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic send_frame(input logic [111:0] d);
        flag = 1'b0;
        step(3);
        data = d;
        flag = 1'b1;
        step(5);
    endtask

    task automatic apply_tick(output int pulses);
        pulses = 0;
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        repeat (10) begin
            step(1);
            if (cv_valid) pulses++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (cv !== 112'd0) begin errors++; $display("FAIL reset_cv: got %h expected 0", cv); end
        checks++; if (cv_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", cv_valid); end
        checks++; if (link_ok !== 1'b0) begin errors++; $display("FAIL reset_link: got %b expected 0", link_ok); end
        checks++; if (fcount !== 8'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fcount); end
    endtask

    task automatic test_basic_apply();
        logic [111:0] f;
        f = seq_frame(16'h0100, 16'h0100);
        do_reset();
        data = f;
        flag = 1'b1;
        step(10);
        checks++; if (link_ok !== 1'b1) begin errors++; $display("FAIL basic_link: got %b expected 1", link_ok); end
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        for (int k = 0; k < 7; k++) begin
            step(1);
            checks++; if (cv[k*16 +: 16] !== f[k*16 +: 16]) begin errors++; $display("FAIL basic_word%0d: got %h expected %h", k, cv[k*16 +: 16], f[k*16 +: 16]); end
            if (k < 6) begin
                checks++; if (cv[(k+1)*16 +: 16] !== 16'd0) begin errors++; $display("FAIL basic_early%0d: got %h expected 0", k+1, cv[(k+1)*16 +: 16]); end
            end
            checks++; if (cv_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early%0d: got %b expected 0", k, cv_valid); end
        end
        step(1);
        checks++; if (cv_valid !== 1'b1) begin errors++; $display("FAIL basic_valid_8: got %b expected 1", cv_valid); end
        checks++; if (fcount !== 8'd1) begin errors++; $display("FAIL basic_count: got %0d expected 1", fcount); end
        step(1);
        checks++; if (cv_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_9: got %b expected 0", cv_valid); end
    endtask

    task automatic test_reset_flag_high();
        logic [111:0] f;
        int p;
        f = seq_frame(16'h3000, 16'h0003);
        rst = 1'b1; tick = 1'b0; data = f; flag = 1'b1;
        step(3);
        rst = 1'b0;
        step(6);
        apply_tick(p);
        checks++; if (cv !== f) begin errors++; $display("FAIL flag_high_cv: got %h expected %h", cv, f); end
        checks++; if (fcount !== 8'd1) begin errors++; $display("FAIL flag_high_count: got %0d expected 1", fcount); end
    endtask

    task automatic test_newest_wins();
        logic [111:0] fa;
        logic [111:0] fb;
        int p;
        fa = seq_frame(16'h1111, 16'h1111);
        fb = seq_frame(16'hA000, 16'h0010);
        do_reset();
        send_frame(fa);
        send_frame(fb);
        apply_tick(p);
        checks++; if (p !== 1) begin errors++; $display("FAIL newest_pulses: got %0d expected 1", p); end
        checks++; if (cv !== fb) begin errors++; $display("FAIL newest_cv: got %h expected %h", cv, fb); end
        checks++; if (fcount !== 8'd1) begin errors++; $display("FAIL newest_count: got %0d expected 1", fcount); end
    endtask

    task automatic test_torn_frame();
        logic [111:0] fx;
        int p;
        fx = seq_frame(16'h0555, 16'h0101);
        do_reset();
        send_frame(fx);
        apply_tick(p);
        flag = 1'b0;
        step(3);
        data = seq_frame(16'hBEEF, 16'h0001);
        flag = 1'b1;
        step(1);
        flag = 1'b0;
        step(6);
        apply_tick(p);
        checks++; if (p !== 0) begin errors++; $display("FAIL torn_pulses: got %0d expected 0", p); end
        checks++; if (cv !== fx) begin errors++; $display("FAIL torn_cv: got %h expected %h", cv, fx); end
        checks++; if (fcount !== 8'd1) begin errors++; $display("FAIL torn_count: got %0d expected 1", fcount); end
    endtask

    task automatic test_edge_during_apply();
        logic [111:0] fa;
        logic [111:0] fb;
        int p;
        fa = seq_frame(16'h2000, 16'h0202);
        fb = seq_frame(16'hC000, 16'h0040);
        do_reset();
        send_frame(fa);
        flag = 1'b0;
        step(3);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        data = fb;
        flag = 1'b1;
        step(8);
        checks++; if (cv_valid !== 1'b1) begin errors++; $display("FAIL mid_valid: got %b expected 1", cv_valid); end
        checks++; if (cv !== fa) begin errors++; $display("FAIL mid_cv_a: got %h expected %h", cv, fa); end
        step(5);
        checks++; if (cv !== fa) begin errors++; $display("FAIL mid_hold_a: got %h expected %h", cv, fa); end
        checks++; if (fcount !== 8'd1) begin errors++; $display("FAIL mid_count_a: got %0d expected 1", fcount); end
        apply_tick(p);
        checks++; if (cv !== fb) begin errors++; $display("FAIL mid_cv_b: got %h expected %h", cv, fb); end
        checks++; if (fcount !== 8'd2) begin errors++; $display("FAIL mid_count_b: got %0d expected 2", fcount); end
    endtask

    task automatic test_watchdog();
        logic [111:0] f;
        f = seq_frame(16'h0F00, 16'h0011);
        do_reset();
        data = f;
        flag = 1'b1;
        step(4);
        checks++; if (link_ok !== 1'b1) begin errors++; $display("FAIL wd_link_up: got %b expected 1", link_ok); end
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(62);
        checks++; if (link_ok !== 1'b1) begin errors++; $display("FAIL wd_link_before: got %b expected 1", link_ok); end
        step(1);
        checks++; if (link_ok !== 1'b0) begin errors++; $display("FAIL wd_link_drop: got %b expected 0", link_ok); end
        checks++; if (cv !== f) begin errors++; $display("FAIL wd_cv_hold: got %h expected %h", cv, f); end
        step(20);
        checks++; if (link_ok !== 1'b0) begin errors++; $display("FAIL wd_link_stay: got %b expected 0", link_ok); end
        flag = 1'b0;
        step(3);
        flag = 1'b1;
        step(3);
        checks++; if (link_ok !== 1'b0) begin errors++; $display("FAIL wd_link_precap: got %b expected 0", link_ok); end
        step(1);
        checks++; if (link_ok !== 1'b1) begin errors++; $display("FAIL wd_link_recover: got %b expected 1", link_ok); end
    endtask

    task automatic test_reset_mid_apply();
        do_reset();
        send_frame(seq_frame(16'h7777, 16'h0100));
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        flag = 1'b0;
        step(1);
        checks++; if (cv !== 112'd0) begin errors++; $display("FAIL rstmid_cv: got %h expected 0", cv); end
        checks++; if (fcount !== 8'd0) begin errors++; $display("FAIL rstmid_count: got %0d expected 0", fcount); end
        checks++; if (link_ok !== 1'b0) begin errors++; $display("FAIL rstmid_link: got %b expected 0", link_ok); end
    endtask

`ifdef CV_SLEW_EN
    task automatic test_slew();
        logic [111:0] f;
        int p;
        f = '0;
        f[15:0] = 16'h0C00;
        do_reset();
        send_frame(f);
        for (int n = 1; n <= 6; n++) begin
            apply_tick(p);
            checks++; if (p !== 1) begin errors++; $display("FAIL slew_pulse%0d: got %0d expected 1", n, p); end
            checks++; if (cv[15:0] !== 16'(n * 512)) begin errors++; $display("FAIL slew_word%0d: got %h expected %h", n, cv[15:0], 16'(n * 512)); end
            checks++; if (fcount !== 8'd1) begin errors++; $display("FAIL slew_count%0d: got %0d expected 1", n, fcount); end
        end
        apply_tick(p);
        checks++; if (p !== 0) begin errors++; $display("FAIL slew_settled: got %0d expected 0", p); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_apply();
        test_reset_flag_high();
        test_newest_wins();
        test_torn_frame();
        test_edge_during_apply();
        test_watchdog();
        test_reset_mid_apply();
`ifdef CV_SLEW_EN
        test_slew();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
